if_byte_fetch: RTL and testbench

//  Instruction fetch unit for the IF stage. Walks the PC through a byte-wide instruction memory.

---
 rtl/if_byte_fetch.sv | 150 +++++++++++++++
 tb/tb_if_byte_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_byte_fetch.sv
// Instruction fetch unit: walks the PC through a byte-wide memory, issuing
// four single-byte reads per instruction and packing them MSB first into a
// 32-bit word handed to ID over a valid/ready handshake. EX redirects take
// priority over every other event; a redirect that leaves a read in flight
// parks the FSM in DRAIN until that stale byte arrives and is dropped.
module if_byte_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_rvalid,
  input  logic [7:0]       mem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] redir_target;

  // Redirect targets are always word aligned.
  assign redir_target = redirect_pc & ~WIDTH'(3);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect decisions depend on whether a read is still in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = redirect_valid ? DRAIN : WAIT;
      WAIT: begin
        if (redirect_valid) begin
          state_d = mem_rvalid ? REQ : DRAIN;
        end else if (mem_rvalid) begin
          state_d = (byte_idx_q == 2'd3) ? OUT : REQ;
        end
      end
      OUT: begin
        if (redirect_valid || instr_ready) begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (mem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: one request pulse per REQ visit, address is pc plus byte offset.
  always_comb begin
    mem_req     = (state_q == REQ);
    mem_addr    = pc_q + WIDTH'(byte_idx_q);
    instr_valid = instr_valid_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

  // Datapath next values: byte packing, PC advance and redirect override.
  always_comb begin
    pc_d          = pc_q;
    byte_idx_d    = byte_idx_q;
    shreg_d       = shreg_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    if (redirect_valid) begin
      pc_d          = redir_target;
      byte_idx_d    = 2'd0;
      shreg_d       = '0;
      instr_valid_d = 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (mem_rvalid) begin
            shreg_d = {shreg_q[15:0], mem_rdata};
            if (byte_idx_q == 2'd3) begin
              instr_d       = {shreg_q, mem_rdata};
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
            end else begin
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
        OUT: begin
          if (instr_ready) begin
            pc_d          = pc_q + WIDTH'(4);
            byte_idx_d    = 2'd0;
            instr_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and handoff registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      byte_idx_q    <= 2'd0;
      instr_q       <= '0;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      byte_idx_q    <= byte_idx_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Byte shift register; every word shifts in four fresh bytes, so no reset is needed.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_if_byte_fetch.sv
// Bench for if_byte_fetch: byte memory models with programmable latency,
// an address scoreboard and an instruction scoreboard, a table of fetch
// records, and hand-written redirect / reset / wrap sequences.
module tb_if_byte_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req;
  logic [7:0]  w_addr;
  logic        w_rvalid;
  logic [7:0]  w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [7:0]  w_ipc;

  always #5 clk = ~clk;

  if_byte_fetch #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  if_byte_fetch #(.WIDTH(8), .RESET_PC(8'hFC)) dut_w (
    .clk(clk), .rst(rst), .mem_req(w_req), .mem_addr(w_addr),
    .mem_rvalid(w_rvalid), .mem_rdata(w_rdata), .instr_valid(w_valid),
    .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_ipc),
    .redirect_valid(1'b0), .redirect_pc(8'h00)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    int          lat;
    int          hold;
  } vec_t;

  logic [7:0]  mem [0:255];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] addr_q [$];
  logic [63:0] iexp_q [$];
  logic [63:0] wexp [0:1];
  int          wn = 0;
  int          lat_m = 1;
  bit          addr_chk_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  task automatic push_fetch(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) addr_q.push_back(pc + k);
    iexp_q.push_back({word_at(pc[7:0]), pc});
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!instr_valid && n < 300);
    if (!instr_valid) chk("valid_timeout", {63'd0, instr_valid}, 64'd1);
  endtask

  task automatic handshake();
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
  endtask

  task automatic hold_check(input int cycles);
    logic [31:0] w, p;
    w = instr;
    p = instr_pc;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, instr_valid}, 64'd1);
      chk("bp_instr", {32'd0, instr}, {32'd0, w});
      chk("bp_pc", {32'd0, instr_pc}, {32'd0, p});
      chk("bp_no_req", {63'd0, mem_req}, 64'd0);
    end
  endtask

  // Main memory model: response lat_m cycles after the request cycle.
  initial begin
    int cnt;
    logic [31:0] a;
    cnt = 0;
    a = '0;
    mem_rvalid = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem[a[7:0]];
          end
        end
        if (mem_req) begin
          a = mem_addr;
          cnt = lat_m;
        end
      end
    end
  end

  // Wrap-instance memory model, fixed 1-cycle latency.
  initial begin
    bit pend;
    logic [7:0] a;
    pend = 1'b0;
    a = '0;
    w_rvalid = 1'b0;
    w_rdata = 8'h00;
    forever begin
      @(negedge clk);
      w_rvalid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          w_rvalid = 1'b1;
          w_rdata = mem[a];
          pend = 1'b0;
        end
        if (w_req) begin
          a = w_addr;
          pend = 1'b1;
        end
      end
    end
  end

  // Address scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (addr_chk_en && !rst && mem_req) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_req", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = addr_q.pop_front();
          chk("mem_addr", {32'd0, mem_addr}, {32'd0, e});
        end
      end
    end
  end

  // Instruction scoreboard, compared at each completed handshake.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready) begin
        if (iexp_q.size() == 0) begin
          chk("unexpected_instr", {instr, instr_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = iexp_q.pop_front();
          chk("instr", {32'd0, instr}, {32'd0, e[63:32]});
          chk("instr_pc", {32'd0, instr_pc}, {32'd0, e[31:0]});
        end
      end
    end
  end

  // Wrap-instance monitor: first two words only.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && w_valid && wn < 2) begin
        chk("wrap_instr", {32'd0, w_instr}, {32'd0, wexp[wn][63:32]});
        chk("wrap_pc", {56'd0, w_ipc}, {56'd0, wexp[wn][7:0]});
        wn++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [0:3];
    int n;

    tbl[0] = '{word: 32'h1234_5678, pc: 32'h04, lat: 1, hold: 0};
    tbl[1] = '{word: 32'hDEAD_BEEF, pc: 32'h08, lat: 2, hold: 2};
    tbl[2] = '{word: 32'h0000_00FF, pc: 32'h0C, lat: 4, hold: 0};
    tbl[3] = '{word: 32'hFF00_A55A, pc: 32'h10, lat: 1, hold: 3};

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h00; mem[1] = 8'h50; mem[2] = 8'h00; mem[3] = 8'h93;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) mem[tbl[i].pc[7:0] + 8'(b)] = tbl[i].word[31 - 8*b -: 8];
    end
    wexp[0] = {word_at(8'hFC), 32'h0000_00FC};
    wexp[1] = {word_at(8'h00), 32'h0000_0000};

    rst = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_instr_pc", {32'd0, instr_pc}, 64'd0);
    chk("rst_wrap_pc", {56'd0, w_ipc}, 64'hFC);

    push_fetch(32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    wait_valid(n);
    chk("first_latency", 64'(n), 64'd9);
    chk("first_instr", {32'd0, instr}, 64'h0050_0093);
    chk("first_pc", {32'd0, instr_pc}, 64'd0);

    hold_check(5);
    lat_m = tbl[0].lat;
    push_fetch(tbl[0].pc);
    handshake();

    for (int i = 0; i < 4; i++) begin
      wait_valid(n);
      chk("tbl_pc", {32'd0, instr_pc}, {32'd0, tbl[i].pc});
      chk("tbl_word", {32'd0, instr}, {32'd0, tbl[i].word});
      hold_check(tbl[i].hold);
      if (i < 3) begin
        lat_m = tbl[i+1].lat;
        push_fetch(tbl[i+1].pc);
        handshake();
      end
    end

    // Redirect while waiting on a 3-cycle read: stale byte drained.
    lat_m = 3;
    addr_q.push_back(32'h14);
    push_fetch(32'h40);
    instr_ready = 1'b1;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    chk("redir_wait_noreq", {63'd0, mem_req}, 64'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    chk("drain_noreq0", {63'd0, mem_req}, 64'd0);
    chk("drain_valid", {63'd0, instr_valid}, 64'd0);
    @(posedge clk); #1;
    chk("drain_noreq1", {63'd0, mem_req}, 64'd0);
    @(posedge clk); #1;
    chk("drain_exit_req", {63'd0, mem_req}, 64'd1);
    chk("drain_exit_addr", {32'd0, mem_addr}, 64'h40);
    wait_valid(n);
    chk("redir_pc", {32'd0, instr_pc}, 64'h40);

    // Redirect coincident with instr_ready in OUT.
    lat_m = 1;
    push_fetch(32'h80);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("coinc_valid", {63'd0, instr_valid}, 64'd0);
    chk("coinc_req", {63'd0, mem_req}, 64'd1);
    chk("coinc_addr", {32'd0, mem_addr}, 64'h80);
    wait_valid(n);
    chk("coinc_pc", {32'd0, instr_pc}, 64'h80);

    // Async reset in WAIT with byte_idx=2.
    addr_q.push_back(32'h84);
    addr_q.push_back(32'h85);
    addr_q.push_back(32'h86);
    handshake();
    n = 0;
    while (!(mem_req && mem_addr == 32'h86) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_byte2", {63'd0, mem_req}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_req", {63'd0, mem_req}, 64'd0);
    chk("arst_valid", {63'd0, instr_valid}, 64'd0);
    chk("arst_instr", {32'd0, instr}, 64'd0);
    chk("arst_pc", {32'd0, instr_pc}, 64'd0);
    addr_q.delete();
    push_fetch(32'h0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    wait_valid(n);
    chk("restart_latency", 64'(n), 64'd9);
    chk("restart_instr", {32'd0, instr}, 64'h0050_0093);
    chk("addr_q_empty", 64'(addr_q.size()), 64'd0);
    addr_chk_en = 1'b0;
    handshake();
    @(negedge clk); #1;
    chk("instr_q_empty", 64'(iexp_q.size()), 64'd0);
    chk("wrap_count", 64'(wn), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
